// File: rtl/channel_status_collector.sv
// Collects the 192 channel-status bits of each channel-A block and checks the CRC in byte 23.
// Exports C bits 0..31 together with done, kill and crc_err status.
module channel_status_collector #(
  parameter int unsigned BLOCK_LEN = 192,
  parameter logic [7:0]  CRC_POLY  = 8'h1D,
  parameter logic [7:0]  CRC_INIT  = 8'hFF,
  parameter bit          CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sf_valid,
  input  logic        sf_channel,
  input  logic        sf_block_start,
  input  logic        sf_cbit,
  output logic [31:0] cs_word,
  output logic        cs_valid,
  output logic        done,
  output logic        kill,
  output logic        crc_err,
  output logic [7:0]  bit_count
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_COLLECT,
    S_CHECK,
    S_ALIGN
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);
  localparam logic [7:0] CRC_END  = 8'(BLOCK_LEN - 8);

  state_t r_state;
  state_t w_state_nxt;

  logic [BLOCK_LEN-1:0] r_shift;
  logic [7:0]           r_crc;
  logic [7:0]           r_rx_crc;
  logic [7:0]           r_bit_count;
  logic [31:0]          r_cs_word;
  logic                 r_cs_valid;
  logic                 r_done;
  logic                 r_kill;
  logic                 r_crc_err;

  logic r_skid_vld;
  logic r_skid_z;
  logic r_skid_c;

  logic w_live;
  logic w_in_check;
  logic w_ev;
  logic w_ev_z;
  logic w_ev_c;
  logic w_skid_load;
  logic w_skid_ovf;
  logic w_start;
  logic w_store;
  logic w_check;
  logic w_misalign;
  logic w_crc_bad;
  logic w_kill_set;

  function automatic logic [7:0] f_crc_step(input logic [7:0] crc, input logic cbit);
    logic w_fb;
    w_fb = crc[7] ^ cbit;
    return {crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] f_rev8(input logic [7:0] v);
    return {<<{v}};
  endfunction

  // A subframe landing during CHECK waits in the skid; while the skid holds data
  // it stays one subframe behind the live input so arrival order is preserved.
  always_comb begin
    w_live      = sf_valid && !sf_channel;
    w_in_check  = (r_state == S_CHECK);
    w_ev        = !w_in_check && (r_skid_vld || w_live);
    w_ev_z      = r_skid_vld ? r_skid_z : sf_block_start;
    w_ev_c      = r_skid_vld ? r_skid_c : sf_cbit;
    w_skid_load = w_in_check ? !r_skid_vld : r_skid_vld;
    w_skid_ovf  = w_in_check && r_skid_vld && w_live;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_vld <= 1'b0;
      r_skid_z   <= 1'b0;
      r_skid_c   <= 1'b0;
    end else begin
      r_skid_vld <= w_in_check ? (r_skid_vld || w_live) : (r_skid_vld && w_live);
      if (w_skid_load) begin
        r_skid_z <= sf_block_start;
        r_skid_c <= sf_cbit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_SEARCH:  if (w_ev && w_ev_z) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_ev && !w_ev_z && (r_bit_count == LAST_IDX)) w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = S_ALIGN;
      S_ALIGN:   if (w_ev) w_state_nxt = w_ev_z ? S_COLLECT : S_SEARCH;
      default:   w_state_nxt = S_SEARCH;
    endcase
  end

  always_comb begin
    w_start    = 1'b0;
    w_store    = 1'b0;
    w_check    = 1'b0;
    w_misalign = 1'b0;
    unique case (r_state)
      S_SEARCH: w_start = w_ev && w_ev_z;
      S_COLLECT: begin
        w_start    = w_ev && w_ev_z;
        w_misalign = w_ev && w_ev_z;
        w_store    = w_ev && !w_ev_z;
      end
      S_CHECK: w_check = 1'b1;
      S_ALIGN: begin
        w_start    = w_ev && w_ev_z;
        w_misalign = w_ev && !w_ev_z;
      end
      default: ;
    endcase
  end

  // The transmitter sends the CRC MSB first, so the LSB-first byte is its mirror.
  always_comb begin
    w_crc_bad  = CHECK_CRC && (r_rx_crc != f_rev8(r_crc));
    w_kill_set = w_misalign || w_skid_ovf || (w_check && w_crc_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_crc       <= CRC_INIT;
      r_rx_crc    <= '0;
      r_bit_count <= '0;
      r_cs_word   <= '0;
      r_cs_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_kill      <= 1'b0;
      r_crc_err   <= 1'b0;
    end else begin
      r_cs_valid <= w_check;
      if (w_start) begin
        r_shift     <= {w_ev_c, r_shift[BLOCK_LEN-1:1]};
        r_crc       <= f_crc_step(CRC_INIT, w_ev_c);
        r_bit_count <= 8'd1;
      end else if (w_store) begin
        r_shift <= {w_ev_c, r_shift[BLOCK_LEN-1:1]};
        if (r_bit_count < CRC_END) r_crc <= f_crc_step(r_crc, w_ev_c);
        else                       r_rx_crc <= {w_ev_c, r_rx_crc[7:1]};
        if (r_bit_count != LAST_IDX) r_bit_count <= r_bit_count + 8'd1;
      end else if (w_check) begin
        r_cs_word   <= r_shift[31:0];
        r_done      <= 1'b1;
        r_crc_err   <= w_crc_bad;
        r_crc       <= CRC_INIT;
        r_bit_count <= '0;
      end
      if (w_kill_set) r_kill <= 1'b1;
    end
  end

  assign cs_word   = r_cs_word;
  assign cs_valid  = r_cs_valid;
  assign done      = r_done;
  assign kill      = r_kill;
  assign crc_err   = r_crc_err;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_channel_status_collector.sv
// Bench for channel_status_collector: block-level vector table, hand-written corner
// sequences, and a randomized stream checked against a byte-wise CRC block model.
module tb_channel_status_collector;

  localparam int BL = 192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sf_valid = 1'b0;
  logic        sf_channel = 1'b0;
  logic        sf_block_start = 1'b0;
  logic        sf_cbit = 1'b0;
  logic [31:0] cs_word;
  logic        cs_valid;
  logic        done;
  logic        kill;
  logic        crc_err;
  logic [7:0]  bit_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  channel_status_collector #(
    .BLOCK_LEN(192),
    .CRC_POLY (8'h1D),
    .CRC_INIT (8'hFF),
    .CHECK_CRC(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sf_valid      (sf_valid),
    .sf_channel    (sf_channel),
    .sf_block_start(sf_block_start),
    .sf_cbit       (sf_cbit),
    .cs_word       (cs_word),
    .cs_valid      (cs_valid),
    .done          (done),
    .kill          (kill),
    .crc_err       (crc_err),
    .bit_count     (bit_count)
  );

  typedef struct {
    logic [31:0] w;
    logic        e;
    logic        k;
  } pulse_t;

  typedef struct packed {
    logic z;
    logic c;
  } sf_t;

  typedef struct {
    logic [31:0] pat;
    int          flip;
    int          early_z;
    bit          inter;
    logic [31:0] exp_word;
    logic        exp_err;
    logic        exp_kill;
  } vec_t;

  pulse_t got_q[$];
  pulse_t exp_q[$];
  sf_t    a_q[$];
  vec_t   vt[7];

  always @(negedge clk) begin
    if (cs_valid === 1'b1) got_q.push_back('{cs_word, crc_err, kill});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    return {<<{v}};
  endfunction

  // Byte-wise CRC over bytes 0..22, each byte taken LSB-first on the wire.
  function automatic logic [7:0] ref_crc(input logic [BL-1:0] b);
    logic [7:0] crc;
    crc = 8'hFF;
    for (int k = 0; k < (BL / 8) - 1; k++) begin
      crc ^= rev8(b[8*k +: 8]);
      for (int j = 0; j < 8; j++) crc = crc[7] ? ((crc << 1) ^ 8'h1D) : (crc << 1);
    end
    return crc;
  endfunction

  function automatic logic [BL-1:0] make_block(input logic [BL-9:0] payload);
    logic [BL-1:0] b;
    b = {8'h00, payload};
    b[BL-1 -: 8] = rev8(ref_crc(b));
    return b;
  endfunction

  function automatic logic [BL-9:0] rand_payload();
    logic [BL-9:0] p;
    for (int i = 0; i < BL - 8; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic cyc(input logic v, input logic ch, input logic z, input logic c);
    sf_valid = v; sf_channel = ch; sf_block_start = z; sf_cbit = c;
    @(posedge clk);
    #1;
    sf_valid = 1'b0; sf_channel = 1'b0; sf_block_start = 1'b0; sf_cbit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_a(input logic z, input logic c, input bit inter);
    cyc(1'b1, 1'b0, z, c);
    if (inter) cyc(1'b1, 1'b1, 1'b1, ~c);
    else       idle(1);
  endtask

  task automatic send_block(input logic [BL-1:0] b, input bit inter);
    for (int i = 0; i < BL; i++) send_a(i == 0, b[i], inter);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    got_q.delete();
  endtask

  initial begin
    logic [BL-1:0] blk;
    logic [BL-1:0] junk;
    logic [BL-1:0] b2;
    logic [BL-1:0] mb;
    int            mode;
    int            cnt;
    int            kind;
    int            len;
    int            idx;
    logic          mk;
    logic          md;
    logic          err;

    vt[0] = '{32'h0000_0000, -1, -1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vt[1] = '{32'h0000_0000, 190, -1, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[2] = '{32'hA5A5_0F0F, -1, 57, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b1};
    vt[3] = '{32'h0000_002B, -1, -1, 1'b1, 32'h0000_002B, 1'b0, 1'b0};
    vt[4] = '{32'hDEAD_BEEF, -1, -1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[5] = '{32'hFFFF_FFFF, 184, -1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vt[6] = '{32'h8000_0001, 5, -1, 1'b0, 32'h8000_0021, 1'b1, 1'b1};

    do_reset();
    chk("rst_cs_word", cs_word, 32'h0);
    chk("rst_cs_valid", 32'(cs_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_kill", 32'(kill), 32'h0);
    chk("rst_crc_err", 32'(crc_err), 32'h0);
    chk("rst_bit_count", 32'(bit_count), 32'h0);

    for (int t = 0; t < 7; t++) begin
      do_reset();
      blk = make_block({{(BL - 40){1'b0}}, vt[t].pat});
      if (vt[t].flip >= 0) blk[vt[t].flip] = ~blk[vt[t].flip];
      if (vt[t].early_z >= 0) begin
        junk = make_block({(BL - 8){1'b1}});
        for (int i = 0; i < vt[t].early_z; i++) send_a(i == 0, junk[i], 1'b0);
        chk($sformatf("v%0d_early_cnt", t), 32'(bit_count), 32'(vt[t].early_z));
      end
      send_block(blk, vt[t].inter);
      idle(3);
      chk($sformatf("v%0d_pulses", t), 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk($sformatf("v%0d_pulse_word", t), got_q[0].w, vt[t].exp_word);
      chk($sformatf("v%0d_cs_word", t), cs_word, vt[t].exp_word);
      chk($sformatf("v%0d_crc_err", t), 32'(crc_err), 32'(vt[t].exp_err));
      chk($sformatf("v%0d_kill", t), 32'(kill), 32'(vt[t].exp_kill));
      chk($sformatf("v%0d_done", t), 32'(done), 32'd1);
      chk($sformatf("v%0d_bit_count", t), 32'(bit_count), 32'd0);
    end

    // Reset in the middle of a block, then a clean block with exact latency.
    do_reset();
    send_block(make_block({{(BL - 40){1'b0}}, 32'hDEAD_BEEF}), 1'b0);
    blk = make_block(rand_payload());
    for (int i = 0; i < 100; i++) send_a(i == 0, blk[i], 1'b0);
    chk("mid_bit_count", 32'(bit_count), 32'd100);
    chk("mid_done_before", 32'(done), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_word", cs_word, 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_bit_count", 32'(bit_count), 32'h0);
    chk("mid_rst_flags", {29'h0, kill, crc_err, cs_valid}, 32'h0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < BL - 1; i++) send_a(i == 0, blk[i], 1'b0);
    cyc(1'b1, 1'b0, 1'b0, blk[BL-1]);
    chk("lat_cs_valid_t0", 32'(cs_valid), 32'h0);
    idle(1);
    chk("lat_cs_valid_t1", 32'(cs_valid), 32'h1);
    chk("lat_cs_word", cs_word, blk[31:0]);
    idle(1);
    chk("lat_cs_valid_t2", 32'(cs_valid), 32'h0);
    chk("lat_done", 32'(done), 32'h1);
    chk("lat_crc_err", 32'(crc_err), 32'h0);
    chk("lat_kill", 32'(kill), 32'h0);

    // First subframe after a block lacks Z.
    send_a(1'b0, 1'b1, 1'b0);
    chk("align_kill", 32'(kill), 32'h1);
    chk("align_bit_count", 32'(bit_count), 32'h0);

    // Two blocks back-to-back with sf_valid every cycle.
    do_reset();
    blk = make_block(rand_payload());
    b2  = make_block(rand_payload());
    for (int i = 0; i < BL; i++) cyc(1'b1, 1'b0, i == 0, blk[i]);
    for (int i = 0; i < BL; i++) cyc(1'b1, 1'b0, i == 0, b2[i]);
    idle(4);
    chk("b2b_pulses", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("b2b_word0", got_q[0].w, blk[31:0]);
      chk("b2b_err0", 32'(got_q[0].e), 32'h0);
      chk("b2b_word1", got_q[1].w, b2[31:0]);
      chk("b2b_err1", 32'(got_q[1].e), 32'h0);
    end
    chk("b2b_kill", 32'(kill), 32'h0);

    // Randomized stream against the block-level model.
    do_reset();
    a_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) a_q.push_back('{1'b0, 1'($urandom_range(0, 1))});
    for (int n = 0; n < 12; n++) begin
      blk  = make_block(rand_payload());
      kind = $urandom_range(0, 9);
      if (kind == 2) begin
        idx = $urandom_range(1, BL - 1);
        blk[idx] = ~blk[idx];
      end
      len = (kind == 0) ? $urandom_range(1, BL - 2) : BL;
      for (int i = 0; i < len; i++) a_q.push_back('{i == 0, blk[i]});
      if (kind == 1) a_q.push_back('{1'b0, 1'($urandom_range(0, 1))});
    end

    mode = 0; cnt = 0; mk = 1'b0; md = 1'b0; mb = '0;
    foreach (a_q[i]) begin
      if (mode == 1 && !a_q[i].z) begin
        mb[cnt] = a_q[i].c;
        cnt++;
        if (cnt == BL) begin
          err = (mb[BL-1 -: 8] != rev8(ref_crc(mb)));
          md  = 1'b1;
          if (err) mk = 1'b1;
          exp_q.push_back('{mb[31:0], err, mk});
          mode = 2;
        end
      end else if (a_q[i].z) begin
        if (mode == 1) mk = 1'b1;
        mb[0] = a_q[i].c;
        cnt   = 1;
        mode  = 1;
      end else if (mode == 2) begin
        mk   = 1'b1;
        mode = 0;
      end
    end

    foreach (a_q[i]) begin
      cyc(1'b1, 1'b0, a_q[i].z, a_q[i].c);
      repeat ($urandom_range(1, 3)) begin
        if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else idle(1);
      end
    end
    idle(4);

    chk("rnd_pulses", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rnd%0d_word", i), got_q[i].w, exp_q[i].w);
      chk($sformatf("rnd%0d_err", i), 32'(got_q[i].e), 32'(exp_q[i].e));
      chk($sformatf("rnd%0d_kill", i), 32'(got_q[i].k), 32'(exp_q[i].k));
    end
    chk("rnd_final_kill", 32'(kill), 32'(mk));
    chk("rnd_final_done", 32'(done), 32'(md));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
